// File: rtl/fifo_read_stream.sv
// Read-side output stage of the async FIFO: pops words into a 2-entry skid buffer and presents them on a valid/ready stream.
// Optional transfer counter output xfer_Count is enabled by defining FIFO_READ_STREAM_XFER_CNT_EN.
module fifo_read_stream #(
    parameter int data_Size = 8
) (
    input  logic                 r_Clk,
    input  logic                 r_Rst,
    input  logic                 fifo_Empty,
    input  logic [data_Size-1:0] r_Data,
    output logic                 r_Inc,
    output logic                 m_Valid,
    input  logic                 m_Ready,
    output logic [data_Size-1:0] m_Data,
    output logic [1:0]           buf_Level
`ifdef FIFO_READ_STREAM_XFER_CNT_EN
    ,
    output logic [15:0]          xfer_Count
`endif
);

    logic [data_Size-1:0] entry_q [2];
    logic                 wr_sel_q;
    logic                 rd_sel_q;
    logic [1:0]           occ_q;
    logic [1:0]           occ_d;
    logic                 pop;
    logic                 xfer;

    // Gated by reset so the increment request is quiet while the read pointer is held in reset.
    assign r_Inc     = r_Rst & ~fifo_Empty & (occ_q != 2'd2);
    assign pop       = r_Inc;
    assign m_Valid   = (occ_q != 2'd0);
    assign xfer      = m_Valid & m_Ready;
    assign m_Data    = entry_q[rd_sel_q];
    assign buf_Level = occ_q;

    always_comb begin
        occ_d = occ_q;
        case ({pop, xfer})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge r_Clk or negedge r_Rst) begin
        if (!r_Rst) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            if (pop) begin
                entry_q[wr_sel_q] <= r_Data;
                wr_sel_q          <= ~wr_sel_q;
            end
            if (xfer) begin
                rd_sel_q <= ~rd_sel_q;
            end
            occ_q <= occ_d;
        end
    end

`ifdef FIFO_READ_STREAM_XFER_CNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge r_Clk or negedge r_Rst) begin
        if (!r_Rst) begin
            xfer_cnt_q <= 16'd0;
        end else if (xfer) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_Count = xfer_cnt_q;
`endif

    // occ_d above 2 would mean an overflow or a wrapped underflow.
    a_occ_range: assert property (@(posedge r_Clk) disable iff (!r_Rst) occ_q <= 2'd2);
    a_occ_next:  assert property (@(posedge r_Clk) disable iff (!r_Rst) occ_d <= 2'd2);

endmodule

// File: tb/tb_fifo_read_stream.sv
// Testbench for fifo_read_stream: vector table for the basic edges, then a FIFO model feeding an in-order scoreboard.
module tb_fifo_read_stream;

    logic       r_Clk = 1'b0;
    logic       r_Rst = 1'b0;
    logic       fifo_Empty = 1'b1;
    logic [7:0] r_Data = 8'h00;
    logic       m_Ready = 1'b0;
    logic       r_Inc;
    logic       m_Valid;
    logic [7:0] m_Data;
    logic [1:0] buf_Level;
`ifdef FIFO_READ_STREAM_XFER_CNT_EN
    logic [15:0] xfer_Count;
`endif

    fifo_read_stream #(.data_Size(8)) dut (
        .r_Clk      (r_Clk),
        .r_Rst      (r_Rst),
        .fifo_Empty (fifo_Empty),
        .r_Data     (r_Data),
        .r_Inc      (r_Inc),
        .m_Valid    (m_Valid),
        .m_Ready    (m_Ready),
        .m_Data     (m_Data),
        .buf_Level  (buf_Level)
`ifdef FIFO_READ_STREAM_XFER_CNT_EN
        ,
        .xfer_Count (xfer_Count)
`endif
    );

    always #5 r_Clk = ~r_Clk;

    typedef struct {
        logic       emp;
        logic [7:0] din;
        logic       rdy;
        logic       inc;
        logic       vld;
        logic [7:0] dout;
        logic [1:0] lvl;
    } vec_t;

    vec_t       tbl [9];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] fifo_q [$];
    logic [7:0] sb_q [$];
    int         occ_m = 0;
    int         n_xfer = 0;
    bit         rdy_rand = 1'b0;
    logic       rdy_fix = 1'b0;
    bit         bubble = 1'b0;
    bit         phase = 1'b0;
    bit         hold_prev = 1'b0;
    logic [7:0] hold_d = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_fifo();
        fifo_Empty = (fifo_q.size() == 0) || (bubble && phase);
        r_Data     = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic set_ready();
        m_Ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    endtask

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        sb_q.push_back(w);
        set_fifo();
    endtask

    // One clock: check outputs against the occupancy model, then advance FIFO model and scoreboard.
    task automatic cycle();
        bit         pop_e;
        bit         xfer_e;
        logic [7:0] d_s;
        logic [7:0] exp_w;
        @(negedge r_Clk);
        pop_e  = !fifo_Empty && (occ_m < 2);
        xfer_e = (occ_m != 0) && m_Ready;
        d_s    = m_Data;
        chk("buf_level", 32'(buf_Level), 32'(occ_m));
        chk("m_valid", 32'(m_Valid), 32'(occ_m != 0));
        chk("r_inc", 32'(r_Inc), 32'(pop_e));
        if (hold_prev) begin
            chk("hold_data", 32'(m_Data), 32'(hold_d));
            chk("hold_valid", 32'(m_Valid), 32'd1);
        end
        hold_prev = m_Valid && !m_Ready;
        hold_d    = m_Data;
        @(posedge r_Clk);
        #1;
        if (pop_e && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (xfer_e) begin
            n_xfer++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_extra: got %0h expected no word", d_s);
            end else begin
                exp_w = sb_q.pop_front();
                chk("stream_data", 32'(d_s), 32'(exp_w));
            end
        end
        occ_m = occ_m + int'(pop_e) - int'(xfer_e);
        phase = ~phase;
        set_fifo();
        set_ready();
    endtask

    task automatic drain(input int max_cyc);
        int k = 0;
        while ((sb_q.size() != 0 || occ_m != 0) && k < max_cyc) begin
            cycle();
            k++;
        end
        chk("drain_left", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x0;
        tbl[0] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};
        tbl[1] = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[2] = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1};
        tbl[3] = '{1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2};
        tbl[4] = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 8'h11, 2'd2};
        tbl[5] = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1};
        tbl[6] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1};
        tbl[7] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 8'h22, 2'd0};
        tbl[8] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h22, 2'd0};

        // Reset: r_Inc must stay low even with a non-empty FIFO.
        fifo_Empty = 1'b0;
        repeat (2) @(posedge r_Clk);
        #1;
        chk("rst_inc", 32'(r_Inc), 32'd0);
        chk("rst_valid", 32'(m_Valid), 32'd0);
        chk("rst_data", 32'(m_Data), 32'd0);
        chk("rst_level", 32'(buf_Level), 32'd0);
        fifo_Empty = 1'b1;
        r_Rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            fifo_Empty = tbl[i].emp;
            r_Data     = tbl[i].din;
            m_Ready    = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_inc", i), 32'(r_Inc), 32'(tbl[i].inc));
            chk($sformatf("tbl%0d_valid", i), 32'(m_Valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_data", i), 32'(m_Data), 32'(tbl[i].dout));
            chk($sformatf("tbl%0d_level", i), 32'(buf_Level), 32'(tbl[i].lvl));
            @(posedge r_Clk);
            #1;
        end

        // Mid-stream asynchronous reset with a full buffer.
        occ_m   = 0;
        rdy_fix = 1'b0;
        set_ready();
        load(8'hA1);
        load(8'hA2);
        load(8'hA3);
        repeat (3) cycle();
        chk("pre_rst_level", 32'(buf_Level), 32'd2);
        #2;
        r_Rst = 1'b0;
        #1;
        chk("async_rst_valid", 32'(m_Valid), 32'd0);
        chk("async_rst_data", 32'(m_Data), 32'd0);
        chk("async_rst_level", 32'(buf_Level), 32'd0);
        chk("async_rst_inc", 32'(r_Inc), 32'd0);
        fifo_q.delete();
        sb_q.delete();
        occ_m     = 0;
        hold_prev = 1'b0;
        set_fifo();
        repeat (2) @(posedge r_Clk);
        #1;
        r_Rst   = 1'b1;
        rdy_fix = 1'b1;
        set_ready();
        x0 = n_xfer;
        repeat (4) cycle();
        chk("no_stale", 32'(n_xfer - x0), 32'd0);

        // Streaming with m_Ready held high.
        x0 = n_xfer;
        for (int i = 0; i < 8; i++) load(8'(8'h11 + i));
        repeat (9) cycle();
        chk("stream_cnt", 32'(n_xfer - x0), 32'd8);
        chk("stream_inc_after", 32'(r_Inc), 32'd0);
        chk("stream_empty_after", 32'(m_Valid), 32'd0);

        // Backpressure.
        rdy_fix = 1'b0;
        set_ready();
        for (int i = 0; i < 4; i++) load(8'(8'h11 + i));
        repeat (5) cycle();
        chk("bp_level", 32'(buf_Level), 32'd2);
        chk("bp_inc", 32'(r_Inc), 32'd0);
        chk("bp_data", 32'(m_Data), 32'h11);
        rdy_fix = 1'b1;
        set_ready();
        drain(20);

        // FIFO empty toggling every cycle.
        bubble = 1'b1;
        for (int i = 0; i < 6; i++) load(8'(8'hC0 + i));
        drain(40);
        chk("bubble_drained", 32'(m_Valid), 32'd0);
        bubble = 1'b0;

        // Random ready, 256 random words.
        rdy_rand = 1'b1;
        for (int i = 0; i < 256; i++) load(8'($urandom_range(0, 255)));
        set_ready();
        drain(2000);
        rdy_rand = 1'b0;
        rdy_fix  = 1'b0;
        set_ready();

`ifdef FIFO_READ_STREAM_XFER_CNT_EN
        begin
            int cnt = 0;
            int k = 0;
            r_Rst = 1'b0;
            #1;
            chk("cnt_rst", 32'(xfer_Count), 32'd0);
            @(posedge r_Clk);
            #1;
            r_Rst      = 1'b1;
            fifo_Empty = 1'b0;
            r_Data     = 8'h5A;
            m_Ready    = 1'b1;
            while (cnt < 70000 && k < 71000) begin
                @(negedge r_Clk);
                if (m_Valid && m_Ready) cnt++;
                k++;
            end
            @(posedge r_Clk);
            #1;
            m_Ready    = 1'b0;
            fifo_Empty = 1'b1;
            #1;
            chk("cnt_xfers", 32'(cnt), 32'd70000);
            chk("cnt_wrap", 32'(xfer_Count), 32'd4464);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
